// File: rtl/machine_keypad.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces
// press and release of the first key found, and reports it as row*4+col.
module machine_keypad #(
  parameter int SETTLE   = 16,
  parameter int DEBOUNCE = 1000
) (
  input  logic       system1000,
  input  logic       system1000_rstn,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

  localparam logic [7:0]  DWELL_LAST = 8'(SETTLE - 1);
  localparam logic [15:0] DB_LAST    = 16'(DEBOUNCE - 1);

  state_t      r_state, w_state_next;
  logic [3:0]  r_sync1, r_srows;
  logic [1:0]  r_col, w_col_next;
  logic [7:0]  r_dwell, w_dwell_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic [1:0]  r_row, w_row_next;
  logic [3:0]  r_pat, w_pat_next;
  logic [3:0]  r_key, w_key_next;
  logic        r_key_valid, w_key_valid_next;
  logic        w_all_high;
  logic [1:0]  w_low_row;

  // rows is asynchronous to the clock; everything below sees only r_srows
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_sync1 <= 4'b1111;
      r_srows <= 4'b1111;
    end else begin
      r_sync1 <= rows;
      r_srows <= r_sync1;
    end
  end

  assign w_all_high = (r_srows == 4'b1111);

  always_comb begin
    w_low_row = 2'd3;
    if (!r_srows[0])      w_low_row = 2'd0;
    else if (!r_srows[1]) w_low_row = 2'd1;
    else if (!r_srows[2]) w_low_row = 2'd2;
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_state     <= SCAN;
      r_col       <= 2'd0;
      r_dwell     <= 8'd0;
      r_cnt       <= 16'd0;
      r_row       <= 2'd0;
      r_pat       <= 4'b1111;
      r_key       <= 4'd0;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_col       <= w_col_next;
      r_dwell     <= w_dwell_next;
      r_cnt       <= w_cnt_next;
      r_row       <= w_row_next;
      r_pat       <= w_pat_next;
      r_key       <= w_key_next;
      r_key_valid <= w_key_valid_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_col_next       = r_col;
    w_dwell_next     = r_dwell;
    w_cnt_next       = r_cnt;
    w_row_next       = r_row;
    w_pat_next       = r_pat;
    w_key_next       = r_key;
    w_key_valid_next = 1'b0;
    case (r_state)
      SCAN: begin
        if (r_dwell != DWELL_LAST) begin
          w_dwell_next = r_dwell + 8'd1;
        end else if (w_all_high) begin
          w_col_next   = r_col + 2'd1;
          w_dwell_next = 8'd0;
        end else begin
          w_row_next   = w_low_row;
          w_pat_next   = r_srows;
          w_cnt_next   = 16'd0;
          w_dwell_next = 8'd0;
          w_state_next = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (w_all_high) begin
          w_col_next   = r_col + 2'd1;
          w_dwell_next = 8'd0;
          w_state_next = SCAN;
        end else if (r_srows != r_pat) begin
          // a bouncing multi-key contact restarts the debounce on the new pattern
          w_pat_next = r_srows;
          w_row_next = w_low_row;
          w_cnt_next = 16'd0;
        end else if (r_cnt == DB_LAST) begin
          w_key_next       = {r_row, r_col};
          w_key_valid_next = 1'b1;
          w_state_next     = HELD;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      HELD: begin
        if (w_all_high) begin
          w_cnt_next   = 16'd0;
          w_state_next = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (!w_all_high) begin
          w_cnt_next   = 16'd0;
          w_state_next = HELD;
        end else if (r_cnt == DB_LAST) begin
          w_col_next   = r_col + 2'd1;
          w_dwell_next = 8'd0;
          w_state_next = SCAN;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
    endcase
  end

  assign cols      = ~(4'b0001 << r_col);
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_held  = (r_state == HELD) || (r_state == RELEASE_DB);

endmodule

// File: tb/tb_machine_keypad.sv
// Scoreboard bench for machine_keypad: stimulus pushes expected key codes,
// a monitor pops them on each key_valid pulse. A keypad matrix model drives rows.
module tb_machine_keypad;

  localparam int SETTLE   = 16;
  localparam int DEBOUNCE = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] mask = 16'h0000;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [3:0]  exp_q[$];

  machine_keypad #(.SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)) dut (
    .system1000      (clk),
    .system1000_rstn (rst_n),
    .rows            (rows),
    .cols            (cols),
    .key             (key),
    .key_valid       (key_valid),
    .key_held        (key_held)
  );

  always #5 clk = ~clk;

  // pressed key (r,c) pulls row r low while column c is driven low
  always_comb begin
    rows = 4'b1111;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (mask[rr*4+cc] && !cols[cc]) rows[rr] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic       prev_valid;
    logic [3:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("cols_onehot", $countones(~cols), 1);
        if (key_valid) begin
          check("valid_two_cycles", int'(prev_valid), 0);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("pulse_key", key, e);
          end
        end
        prev_valid = key_valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  task automatic wait_pulses(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic count_held(output int n);
    n = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (!key_held) break;
      n++;
    end
  endtask

  task automatic wait_col_start(input int c);
    logic [3:0] t;
    logic [3:0] prev;
    int         found;
    t     = ~(4'b0001 << c);
    prev  = cols;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cols == t && prev != t) begin
        found = 1;
        break;
      end
      prev = cols;
    end
    check("col_start_seen", found, 1);
  endtask

  initial begin : stimulus
    logic [3:0] prev;
    int run, first, changes, n;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_cols", cols, 4'b1110);
    check("rst_key", key, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_held", key_held, 0);
    rst_n = 1'b1;

    // idle scanning: rotation order and dwell length
    prev = cols; run = 1; first = 1; changes = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cols == prev) begin
        run++;
      end else begin
        check("idle_rotate", cols, {prev[2:0], prev[3]});
        if (!first) check("idle_dwell", run, SETTLE);
        first = 0; run = 1; prev = cols; changes++;
      end
    end
    check("idle_changes", int'(changes >= 5), 1);

    // clean press row 2 col 1
    @(negedge clk); #1;
    mask = 16'h0200;
    exp_q.push_back(4'd9);
    wait_pulses("press9_pulse");
    check("press9_held", key_held, 1);
    repeat (10) @(negedge clk);
    #1;
    check("press9_still_held", key_held, 1);
    check("press9_key_hold", key, 9);
    mask = 16'h0000;
    count_held(n);
    // two synchronizer cycles, then DEBOUNCE cycles of stable release
    check("press9_release_time", n, 2 + DEBOUNCE);
    check("press9_next_col", cols, 4'b1011);

    // bouncing contact at row 0 col 2, then stable
    wait_col_start(2);
    #1;
    for (int i = 0; i < 40; i++) begin
      mask = (((i / 3) % 2) == 0) ? 16'h0004 : 16'h0000;
      @(negedge clk);
    end
    mask = 16'h0004;
    exp_q.push_back(4'd2);
    wait_pulses("bounce_pulse");
    check("bounce_key", key, 2);
    mask = 16'h0000;
    count_held(n);
    check("bounce_release_time", n, 2 + DEBOUNCE);
    check("bounce_next_col", cols, 4'b0111);

    // rows 1 and 3 on col 0: lowest row wins; extra key while held ignored
    @(negedge clk); #1;
    mask = 16'h1010;
    exp_q.push_back(4'd4);
    wait_pulses("dual_pulse");
    mask = mask | 16'h0001;
    repeat (30) @(negedge clk);
    #1;
    check("dual_still_held", key_held, 1);
    check("dual_key", key, 4);
    mask = 16'h0000;
    count_held(n);
    check("dual_release_time", n, 2 + DEBOUNCE);

    // reset while PRESS_DB counter is 5 (row 0 col 1)
    wait_col_start(1);
    #1;
    mask = 16'h0002;
    // sample at dwell SETTLE-1, then five matching cycles
    repeat (SETTLE + 5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_key_valid", key_valid, 0);
    check("abort_key_held", key_held, 0);
    check("abort_key", key, 0);
    check("abort_cols", cols, 4'b1110);
    mask = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("abort_cols_after", cols, 4'b1110);
    repeat (40) @(negedge clk);

    // release glitch at RELEASE_DB count 6 (row 1 col 3)
    @(negedge clk); #1;
    mask = 16'h0080;
    exp_q.push_back(4'd7);
    wait_pulses("glitch_pulse");
    repeat (5) @(negedge clk);
    #1;
    mask = 16'h0000;
    n = 0;
    for (int j = 1; j < 300; j++) begin
      @(negedge clk);
      if (!key_held) break;
      n++;
      if (j == 7) mask = 16'h0080;
      if (j == 8) mask = 16'h0000;
    end
    // glitch restarts the release debounce 8 cycles later than a clean release
    check("glitch_release_time", n, 2 + DEBOUNCE + 8);
    check("glitch_key", key, 7);

    repeat (5) @(negedge clk);
    check("pending_pulses", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
